egress_collector: RTL and testbench
===================================

# egress_collector

Collects metadata words from the four egress ports and merges them into one FIFO that the host interface drains. It sits directly downstream of the egress ports and directly upstream of the host interface read path, replacing the shared egress output bus. A round-robin arbiter gives each port a fair turn. Each stored word is tagged with its source port.

## Interface
- NUM_PORTS, 4, number of egress ports; power of 2
- META_W, 32, metadata word width
- DEPTH, 16, FIFO entries; power of 2, at least 2
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- egress_in  in  NUM_PORTS*META_W  per-port word; port p occupies bits [p*META_W +: META_W]
- egress_in_en  in  NUM_PORTS  per-port valid; the port holds its word until acked
- egress_in_ack  out  NUM_PORTS  one-hot (or zero) grant; the word transfers on the edge where en and ack are both high
- out_data  out  META_W  FIFO head word
- out_port  out  $clog2(NUM_PORTS)  source port of the head word
- out_valid  out  1  FIFO is non-empty
- out_ack  in  1  pops the head on this edge; ignored when out_valid=0
- clear  in  1  synchronous flush; asserted at experiment start
- level  out  $clog2(DEPTH)+1  current occupancy
- total_cnt  out  32  words accepted since reset or clear; wraps at 2^32

## Operation
- Reset (reset=0, asynchronous): read pointer, write pointer, level, rr_ptr and total_cnt all go to 0. out_valid=0. egress_in_ack is forced to 0 while reset is asserted. FIFO contents are don't-care.
- Arbitration:
  - egress_in_ack is combinational from egress_in_en, rr_ptr, full and clear.
  - Grant the first port with en=1, searching from rr_ptr upward and wrapping.
  - No grant when full (level==DEPTH) or when clear=1.
- Push on a grant:
  - mem[wr_ptr] ← {port, word}; wr_ptr increments and wraps at DEPTH.
  - total_cnt increments.
  - rr_ptr ← granted port + 1 (mod NUM_PORTS).
  - With no grant, rr_ptr holds.
- Pop when out_ack=1 and out_valid=1: rd_ptr increments and wraps.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- Full FIFO: no push is granted, even if a pop occurs in the same cycle; the grant resumes the following cycle.
- Empty FIFO: out_ack is ignored, and level never underflows.
- clear=1 takes priority over push and pop:
  - pointers, level, rr_ptr and total_cnt ← 0
  - no ack is issued in the clear cycle, so words held by the egress ports are preserved
- Exactly one word is accepted per cycle. Each waiting port is granted at least once every NUM_PORTS grants.

## Timing
- Handshake: egress_in_ack is combinational, so a transfer completes in the same cycle as the grant.
- Push-to-visibility latency is 1 cycle: a word pushed at edge N into an empty FIFO gives out_valid=1, with out_data/out_port valid, after edge N.
- out_data, out_port and out_valid are read from registered state; they do not depend combinationally on out_ack.
- Pop effect: after the popping edge, the head advances; out_valid falls if the popped word was the last entry.
- level and total_cnt update on the same edge as the push or pop they count.
- Reset asserted mid-operation discards all FIFO contents. Egress ports keep their held words and re-present them after reset releases.

## Structure
- Shared package switch_pkg:
  - constants NUM_PORTS and META_W
  - typedef port_id_t as logic [$clog2(NUM_PORTS)-1:0]
  - typedef fifo_entry_t as packed struct {port_id_t port; logic [META_W-1:0] meta;}
- Sub-module rr_arbiter:
  - purely combinational
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant and encoded granted port
- Top-level register-file FIFO inside egress_collector: pointers one bit wider than the index, with full/empty derived from pointer comparison.

## Test plan
- Single port: port 2 raises en with 0xDEADBEEF → ack[2] in the same cycle; after the next edge out_valid=1, out_data=0xDEADBEEF, out_port=2, level=1.
- Fairness: all four ports hold en=1 with out_ack=0 → grant order 0,1,2,3,0,… and level counts 1..16.
- Full FIFO: when level=16, no ack is issued. Pulse out_ack for one cycle → level=15, still no ack that cycle. The next cycle acks the next port in rotation and level returns to 16.
- Simultaneous push and pop: level=5 with one port pushing and out_ack=1 every cycle for 10 cycles → level stays 5; total_cnt rises by 10; words drain in FIFO order.
- Clear and reset:
  - clear while level=7 and port 1 is requesting → no ack that cycle; level=0, total_cnt=0; port 1 is acked the next cycle.
  - reset asserted mid-stream → out_valid=0 immediately, before any clock edge.
- Empty pop: out_ack=1 with level=0 → level stays 0, pointers unchanged, out_valid stays 0.

Source files
------------

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_pkg
// Brief    : Shared switch constants and the tagged FIFO entry type.
// Revision : 1.0
// ============================================================================
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int META_W    = 32;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;

    typedef struct packed {
        port_id_t          port;
        logic [META_W-1:0] meta;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches upward from i_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_id_t             i_ptr,
    input  logic                 i_enable,
    output logic [NUM_PORTS-1:0] o_grant,
    output port_id_t             o_grant_port,
    output logic                 o_grant_valid
);

    port_id_t w_idx;

    // NUM_PORTS is a power of two, so the port_id_t sum wraps naturally.
    always_comb begin
        o_grant       = '0;
        o_grant_port  = '0;
        o_grant_valid = 1'b0;
        w_idx         = '0;
        if (i_enable) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                w_idx = i_ptr + port_id_t'(k);
                if (!o_grant_valid && i_req[w_idx]) begin
                    o_grant[w_idx] = 1'b1;
                    o_grant_port   = w_idx;
                    o_grant_valid  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/egress_collector.sv
`default_nettype none
// ============================================================================
// Module   : egress_collector
// Brief    : Round-robin merge of egress metadata into one port-tagged FIFO.
// Revision : 1.0
// ============================================================================
module egress_collector
    import switch_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*META_W-1:0]   egress_in,
    input  logic [NUM_PORTS-1:0]          egress_in_en,
    output logic [NUM_PORTS-1:0]          egress_in_ack,
    output logic [META_W-1:0]             out_data,
    output port_id_t                      out_port,
    output logic                          out_valid,
    input  logic                          out_ack,
    input  logic                          clear,
    output logic [$clog2(DEPTH):0]        level,
    output logic [31:0]                   total_cnt
);

    localparam int                  c_ADDR_W  = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_PTR_ONE = 1;
    localparam port_id_t            c_PORT_ONE = 1;

    logic [c_ADDR_W:0]  r_wr_ptr;
    logic [c_ADDR_W:0]  r_rd_ptr;
    port_id_t           r_rr_ptr;
    logic [31:0]        r_total_cnt;
    fifo_entry_t        r_mem [DEPTH];

    logic [META_W-1:0]    w_words [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_grant;
    port_id_t             w_grant_port;
    logic                 w_grant_valid;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_arb_en;
    fifo_entry_t          w_entry;
    fifo_entry_t          w_head;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_unpack
            assign w_words[p] = egress_in[p*META_W +: META_W];
        end
    endgenerate

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    // Reset gates the grant so no port sees an ack while the FIFO is held.
    assign w_arb_en = reset && !w_full && !clear;

    rr_arbiter u_arb (
        .i_req         (egress_in_en),
        .i_ptr         (r_rr_ptr),
        .i_enable      (w_arb_en),
        .o_grant       (w_grant),
        .o_grant_port  (w_grant_port),
        .o_grant_valid (w_grant_valid)
    );

    assign w_push = w_grant_valid;
    assign w_pop  = out_ack && !w_empty && !clear;

    assign w_entry.port = w_grant_port;
    assign w_entry.meta = w_words[w_grant_port];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rr_ptr    <= '0;
            r_total_cnt <= '0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rr_ptr    <= '0;
            r_total_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PTR_ONE;
                r_total_cnt <= r_total_cnt + 32'd1;
                r_rr_ptr    <= w_grant_port + c_PORT_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign out_data      = w_head.meta;
    assign out_port      = w_head.port;
    assign out_valid     = !w_empty;
    assign level         = r_wr_ptr - r_rd_ptr;
    assign total_cnt     = r_total_cnt;
    assign egress_in_ack = w_grant;

endmodule
`default_nettype wire

// File: tb/tb_egress_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_egress_collector
// Brief    : Directed bench with a queue-based reference model of the collector.
// Revision : 1.0
// ============================================================================
module tb_egress_collector;
    import switch_pkg::*;

    localparam int DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_PORTS*META_W-1:0] egress_in;
    logic [NUM_PORTS-1:0]        egress_in_en = '0;
    logic [NUM_PORTS-1:0]        egress_in_ack;
    logic [META_W-1:0]           out_data;
    port_id_t                    out_port;
    logic                        out_valid;
    logic                        out_ack = 1'b0;
    logic                        clear = 1'b0;
    logic [$clog2(DEPTH):0]      level;
    logic [31:0]                 total_cnt;

    logic [META_W-1:0] port_word [NUM_PORTS];
    logic [META_W-1:0] next_word = 32'hA000_0000;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int                port;
        logic [META_W-1:0] word;
    } exp_t;

    exp_t        m_q[$];
    logic [31:0] m_total = '0;
    int          m_rr = 0;

    always #5 clk = ~clk;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_pack
            assign egress_in[gp*META_W +: META_W] = port_word[gp];
        end
    endgenerate

    egress_collector #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .egress_in     (egress_in),
        .egress_in_en  (egress_in_en),
        .egress_in_ack (egress_in_ack),
        .out_data      (out_data),
        .out_port      (out_port),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .clear         (clear),
        .level         (level),
        .total_cnt     (total_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which port should be granted right now, from the arbitration rules.
    function automatic logic [NUM_PORTS-1:0] model_grant();
        logic [NUM_PORTS-1:0] g;
        g = '0;
        if (!reset || clear || m_q.size() >= DEPTH) return g;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_PORTS;
            if (egress_in_en[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int ack_index(input logic [NUM_PORTS-1:0] a);
        for (int k = 0; k < NUM_PORTS; k++) if (a[k]) return k;
        return 99;
    endfunction

    // Reference model: advances on every rising edge.
    initial begin : model
        logic [NUM_PORTS-1:0] g;
        exp_t e;
        forever begin
            @(posedge clk);
            g = model_grant();
            if (!reset || clear) begin
                m_q.delete();
                m_total = '0;
                m_rr    = 0;
            end else begin
                if (out_ack && m_q.size() > 0) void'(m_q.pop_front());
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (g[k]) begin
                        e.port = k;
                        e.word = port_word[k];
                        m_q.push_back(e);
                        m_total = m_total + 32'd1;
                        m_rr = (k + 1) % NUM_PORTS;
                    end
                end
            end
        end
    end

    // Compare all outputs against the model on every falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_ack",   egress_in_ack, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_level", level, 0);
                chk("rst_total", total_cnt, 0);
            end else begin
                chk("ack",   egress_in_ack, model_grant());
                chk("valid", out_valid, m_q.size() > 0);
                if (m_q.size() > 0) begin
                    chk("data", out_data, m_q[0].word);
                    chk("port", out_port, m_q[0].port);
                end
                chk("level", level, m_q.size());
                chk("total", total_cnt, m_total);
            end
        end
    end

    // One clock; each acked port then presents a fresh word.
    task automatic step();
        logic [NUM_PORTS-1:0] g;
        g = egress_in_ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (g[k]) begin
                port_word[k] = next_word;
                next_word    = next_word + 32'd1;
            end
        end
    endtask

    initial begin : stim
        int gi;
        for (int k = 0; k < NUM_PORTS; k++) port_word[k] = 32'h1000_0000 * (k + 1);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_level", level, 0);
        reset = 1'b1;

        // Single port
        port_word[2] = 32'hDEAD_BEEF;
        egress_in_en = 4'b0100;
        #1 chk("lit_single_ack", egress_in_ack, 4'b0100);
        step();
        egress_in_en = '0;
        chk("lit_single_valid", out_valid, 1);
        chk("lit_single_data",  out_data, 32'hDEAD_BEEF);
        chk("lit_single_port",  out_port, 2);
        chk("lit_single_level", level, 1);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("lit_drain_level", level, 0);

        // Fairness from rr_ptr=0 after a clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        egress_in_en = '1;
        for (int i = 0; i < DEPTH; i++) begin
            #1 gi = ack_index(egress_in_ack);
            chk("lit_fair_port", gi, i % NUM_PORTS);
            step();
            chk("lit_fair_level", level, i + 1);
        end

        // Full FIFO
        chk("lit_full_noack", egress_in_ack, 0);
        out_ack = 1'b1;
        #1 chk("lit_full_pop_noack", egress_in_ack, 0);
        step();
        out_ack = 1'b0;
        chk("lit_full_level15", level, 15);
        chk("lit_full_resume", egress_in_ack, 4'b0001);
        step();
        chk("lit_full_level16", level, 16);

        // Drain to 5, then push and pop together for 10 cycles
        egress_in_en = '0;
        out_ack = 1'b1;
        repeat (11) step();
        chk("lit_level5", level, 5);
        egress_in_en = 4'b1000;
        repeat (10) step();
        chk("lit_pp_level", level, 5);
        chk("lit_pp_total", total_cnt, 27);
        out_ack = 1'b0;
        egress_in_en = 4'b0010;

        // Clear with port 1 requesting
        step();
        step();
        chk("lit_level7", level, 7);
        clear = 1'b1;
        #1 chk("lit_clear_noack", egress_in_ack, 0);
        step();
        clear = 1'b0;
        #1;
        chk("lit_clear_level", level, 0);
        chk("lit_clear_total", total_cnt, 0);
        chk("lit_clear_ack1",  egress_in_ack, 4'b0010);
        step();
        egress_in_en = '0;
        chk("lit_after_clear_level", level, 1);
        chk("lit_after_clear_port",  out_port, 1);

        // Pop on empty
        out_ack = 1'b1;
        step();
        step();
        step();
        chk("lit_empty_level", level, 0);
        chk("lit_empty_valid", out_valid, 0);
        out_ack = 1'b0;

        // Reset mid-stream
        egress_in_en = '1;
        repeat (3) step();
        chk("lit_pre_rst_level", level, 3);
        reset = 1'b0;
        #1;
        chk("lit_async_valid", out_valid, 0);
        chk("lit_async_level", level, 0);
        chk("lit_async_ack",   egress_in_ack, 0);
        step();
        step();
        reset = 1'b1;
        #1 chk("lit_post_rst_ack", egress_in_ack, 4'b0001);
        step();
        chk("lit_post_rst_level", level, 1);
        chk("lit_post_rst_port",  out_port, 0);
        egress_in_en = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
